// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - instruction queue between fetch and decode with head field split
//
// Purpose:
//   DEPTH-entry FIFO of {pc, inst} pairs with valid/ready handshakes on both
//   sides. The head entry is read combinationally and split into MIPS
//   instruction fields, with sign/zero-extended immediates.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   flush             synchronous discard of all entries (redirect)
//   in_valid/in_ready fetch-side handshake, in_pc/in_inst payload
//   out_valid/out_ready decode-side handshake, out_pc/out_inst head payload
//   op..j_index       head instruction fields
//   imm_sext/imm_zext extended immediates
//   is_nop            head instruction is all zeros
//   count             occupied entries
module inst_fetch_queue #(
    parameter int DEPTH     = 4,
    parameter int PC_WIDTH  = 32,
    parameter int EXT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PC_WIDTH-1:0]       in_pc,
    input  logic [31:0]               in_inst,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PC_WIDTH-1:0]       out_pc,
    output logic [31:0]               out_inst,
    output logic [5:0]                op,
    output logic [4:0]                rs,
    output logic [4:0]                rt,
    output logic [4:0]                rd,
    output logic [4:0]                shamt,
    output logic [5:0]                funct,
    output logic [15:0]               imm,
    output logic [25:0]               j_index,
    output logic [EXT_WIDTH-1:0]      imm_sext,
    output logic [EXT_WIDTH-1:0]      imm_zext,
    output logic                      is_nop,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = PC_WIDTH + 32;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Storage is deliberately not reset; validity is tracked by count alone.
    logic [EW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic push;
    logic pop;
    logic wr_en;

    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    assign push  = in_valid && in_ready;
    assign pop   = out_valid && out_ready;
    // A push coinciding with flush is dropped before it reaches storage.
    assign wr_en = push && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth: pointer overflow is the wrap.
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {in_pc, in_inst};
        end
    end

    // Head read: gated to zero when empty so decode never sees stale RAM.
    logic [EW-1:0] head;
    assign head = out_valid ? mem_q[rd_ptr_q] : '0;

    assign out_pc   = head[EW-1:32];
    assign out_inst = head[31:0];
    assign op       = out_inst[31:26];
    assign rs       = out_inst[25:21];
    assign rt       = out_inst[20:16];
    assign rd       = out_inst[15:11];
    assign shamt    = out_inst[10:6];
    assign funct    = out_inst[5:0];
    assign imm      = out_inst[15:0];
    assign j_index  = out_inst[25:0];
    assign is_nop   = out_valid && (out_inst == 32'h0000_0000);

    generate
        if (EXT_WIDTH > 16) begin : g_ext
            assign imm_sext = {{(EXT_WIDTH-16){imm[15]}}, imm};
            assign imm_zext = {{(EXT_WIDTH-16){1'b0}}, imm};
        end else begin : g_noext
            assign imm_sext = imm;
            assign imm_zext = imm;
        end
    endgenerate

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - self-checking bench for inst_fetch_queue
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] j_index;
    logic [31:0] imm_sext, imm_zext;
    logic        is_nop;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    inst_fetch_queue #(.DEPTH(4), .PC_WIDTH(32), .EXT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm(imm), .j_index(j_index), .imm_sext(imm_sext), .imm_zext(imm_zext),
        .is_nop(is_nop), .count(count)
    );

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        rdy;
        logic        fl;
        logic [2:0]  exp_count;
        logic        exp_ir;
        logic        exp_ov;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    vec_t   vecs[$];
    entry_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic rdy, input logic fl, input logic [2:0] c,
                       input logic ir, input logic ov);
        vec_t r;
        r.v = v; r.pc = pc; r.inst = inst; r.rdy = rdy; r.fl = fl;
        r.exp_count = c; r.exp_ir = ir; r.exp_ov = ov;
        vecs.push_back(r);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_head(input string tag);
        check({tag, "_out_pc0"},   out_pc, 0);
        check({tag, "_out_inst0"}, out_inst, 0);
        check({tag, "_fields0"},   {op, rs, rt, rd, shamt, funct, imm, j_index}, 0);
        check({tag, "_ext0"},      {imm_sext, imm_zext}, 0);
        check({tag, "_is_nop0"},   is_nop, 0);
    endtask

    task automatic check_head(input string tag, input entry_t e);
        logic [31:0] i;
        i = e.inst;
        check({tag, "_out_pc"},   out_pc, e.pc);
        check({tag, "_out_inst"}, out_inst, i);
        check({tag, "_op_rs_rt"}, {op, rs, rt}, {i[31:26], i[25:21], i[20:16]});
        check({tag, "_rd_sh_fn"}, {rd, shamt, funct}, {i[15:11], i[10:6], i[5:0]});
        check({tag, "_imm_j"},    {imm, j_index}, {i[15:0], i[25:0]});
        check({tag, "_sext"},     imm_sext, {{16{i[15]}}, i[15:0]});
        check({tag, "_zext"},     imm_zext, {16'h0000, i[15:0]});
        check({tag, "_is_nop"},   is_nop, (i == 32'h0));
    endtask

    function automatic logic [31:0] word(input int g, input int k);
        return (32'h1000_0000 * g) ^ (32'h0123_4567 * (k + 1)) ^ {16'h0, 16'h8000 * (k % 2)};
    endfunction

    function automatic logic [31:0] pcv(input int g, input int k);
        return 32'h0040_0000 + 32'h100 * g + 32'h4 * k;
    endfunction

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst = '0;

        // Test 3: fill to full, held-off fifth word, drain across wrap
        for (int k = 0; k < 4; k++) add(1, pcv(1, k), word(1, k), 0, 0, 3'(k), 1, k != 0);
        add(1, pcv(1, 4), word(1, 4), 0, 0, 4, 0, 1);
        add(1, pcv(1, 4), word(1, 4), 1, 0, 4, 0, 1);
        add(1, pcv(1, 4), word(1, 4), 0, 0, 3, 1, 1);
        for (int k = 4; k >= 1; k--) add(0, 0, 0, 1, 0, 3'(k), k != 4, 1);
        add(0, 0, 0, 0, 0, 0, 1, 0);
        // Test 4: steady push+pop at count 2 for 10 cycles
        add(1, pcv(2, 0), word(2, 0), 0, 0, 0, 1, 0);
        add(1, pcv(2, 1), word(2, 1), 0, 0, 1, 1, 1);
        for (int k = 2; k < 12; k++) add(1, pcv(2, k), word(2, k), 1, 0, 2, 1, 1);
        add(0, 0, 0, 1, 0, 2, 1, 1);
        add(0, 0, 0, 1, 0, 1, 1, 1);
        add(0, 0, 0, 1, 0, 0, 1, 0);
        // Test 5: flush with concurrent push at count 3
        for (int k = 0; k < 3; k++) add(1, pcv(3, k), word(3, k), 0, 0, 3'(k), 1, k != 0);
        add(1, 32'hDEAD_BEE0, 32'hDEAD_BEEF, 0, 1, 3, 1, 1);
        add(0, 0, 0, 0, 0, 0, 1, 0);
        add(1, pcv(4, 0), word(4, 0), 0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 1, 1, 1);
        add(0, 0, 0, 0, 0, 0, 1, 0);

        // Test 1: reset state during and after reset
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_count", count, 0);
        check_zero_head("rst");
        step(); step();
        reset = 1'b0;
        step();
        check("idle_out_valid", out_valid, 0);
        check("idle_in_ready", in_ready, 1);
        check("idle_count", count, 0);
        check_zero_head("idle");

        // Test 2: single push, no bypass, field split
        in_valid = 1'b1; in_pc = 32'h0040_0000; in_inst = 32'h8C22_FFFC;
        #1;
        check("t2_no_bypass", out_valid, 0);
        step();
        in_valid = 1'b0;
        check("t2_out_valid", out_valid, 1);
        check("t2_count", count, 1);
        check("t2_op", op, 6'h23);
        check("t2_rs", rs, 5'd1);
        check("t2_rt", rt, 5'd2);
        check("t2_imm", imm, 16'hFFFC);
        check("t2_sext", imm_sext, 32'hFFFF_FFFC);
        check("t2_zext", imm_zext, 32'h0000_FFFC);
        check("t2_rd_sh_fn", {rd, shamt, funct}, {5'h1F, 5'h1F, 6'h3C});
        check("t2_j_index", j_index, 26'h022_FFFC);
        check("t2_out_pc", out_pc, 32'h0040_0000);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t2_drained", count, 0);

        // Table-driven tests 3-5 with scoreboard for payload order
        foreach (vecs[n]) begin
            string tag;
            tag = $sformatf("v%0d", n);
            in_valid = vecs[n].v; in_pc = vecs[n].pc; in_inst = vecs[n].inst;
            out_ready = vecs[n].rdy; flush = vecs[n].fl;
            #1;
            check({tag, "_count"}, count, vecs[n].exp_count);
            check({tag, "_in_ready"}, in_ready, vecs[n].exp_ir);
            check({tag, "_out_valid"}, out_valid, vecs[n].exp_ov);
            if (vecs[n].exp_ov) begin
                if (sb.size() == 0) check({tag, "_sb_empty"}, 1, 0);
                else check_head(tag, sb[0]);
            end else begin
                check_zero_head(tag);
            end
            if (vecs[n].fl) begin
                sb.delete();
            end else begin
                if (vecs[n].exp_ov && vecs[n].rdy && sb.size() != 0) void'(sb.pop_front());
                if (vecs[n].v && vecs[n].exp_ir) begin
                    entry_t e;
                    e.pc = vecs[n].pc; e.inst = vecs[n].inst;
                    sb.push_back(e);
                end
            end
            step();
        end
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        check("sb_empty_end", sb.size(), 0);

        // Test 6: async reset mid-cycle with count 3, then NOP detection
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_pc = pcv(5, k); in_inst = word(5, k);
            step();
        end
        in_valid = 1'b0;
        check("t6_count3", count, 3);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_out_valid", out_valid, 0);
        check("t6_async_count", count, 0);
        check("t6_async_in_ready", in_ready, 1);
        step();
        reset = 1'b0;
        in_valid = 1'b1; in_pc = 32'h0040_0100; in_inst = 32'h0000_0000;
        step();
        in_valid = 1'b0;
        check("t6_out_valid", out_valid, 1);
        check("t6_is_nop", is_nop, 1);
        check("t6_funct", funct, 0);
        check("t6_out_pc", out_pc, 32'h0040_0100);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t6_empty_is_nop", is_nop, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
